// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus arbiter: the broadcast packet and
// the default tag/value widths it is built from.
package cdb_pkg;

    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_tag;
        logic [DATA_W-1:0] value;
        logic              is_branch;
        logic              taken;
    } cdb_pkt_t;

    // Width of a source index; never below one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source-side and broadcast-side signals of the CDB arbiter.
// master = arbiter, slave = functional units / broadcast consumers.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 5,
    parameter int NUM_LANES = 1
);
    localparam int PTR_W = ptr_w(NUM_SRC);

    // valid/yumi: a source raises src_valid with src_pkt and holds both
    // stable until it sees src_yumi high at a rising edge; yumi is a
    // same-cycle consume strobe and is only ever high where valid is high.
    logic [NUM_SRC-1:0]     src_valid;
    cdb_pkt_t [NUM_SRC-1:0] src_pkt;
    logic [NUM_SRC-1:0]     src_yumi;

    cdb_pkt_t [NUM_LANES-1:0] cdb_out;
    logic [NUM_LANES-1:0]     cdb_valid;
    logic [15:0]              bcast_cnt;
    logic [PTR_W-1:0]         rr_ptr;

    modport master (
        input  src_valid, src_pkt,
        output src_yumi, cdb_out, cdb_valid, bcast_cnt, rr_ptr
    );

    modport slave (
        output src_valid, src_pkt,
        input  src_yumi, cdb_out, cdb_valid, bcast_cnt, rr_ptr
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot round-robin picker: first set bit of mask at or after ptr,
// wrapping through N-1 back to 0.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N     = 5,
    parameter int PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] index
);

    logic             hit;
    logic [PTR_W-1:0] pos;

    always_comb begin
        onehot = '0;
        index  = '0;
        hit    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = PTR_W'((int'(ptr) + k) % N);
            if (!hit && mask[pos]) begin
                hit         = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_LANES result sources per cycle onto
// the CDB. Define CDB_OUT_REG_EN to register cdb_out/cdb_valid (1-cycle latency).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 5,
    parameter int NUM_LANES = 1,
    parameter int ROB_W     = cdb_pkg::ROB_W,
    parameter int DATA_W    = cdb_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.master bus
);

    localparam int PKT_W = ROB_W + DATA_W + 2;
    localparam int PTR_W = ptr_w(NUM_SRC);

    logic [NUM_LANES-1:0][NUM_SRC-1:0] mask;
    logic [NUM_LANES-1:0][NUM_SRC-1:0] onehot;
    logic [NUM_LANES-1:0][PTR_W-1:0]   index;
    logic [NUM_LANES-1:0][PKT_W-1:0]   lane_bits;
    logic [NUM_LANES-1:0]              lane_hit;
    logic [NUM_SRC-1:0]                grant;
    logic [PTR_W-1:0]                  rr_ptr, next_ptr;
    logic [15:0]                       cnt;
    logic [1:0]                        n_bcast;
    logic [16:0]                       cnt_sum;

    // Each later lane searches only the sources earlier lanes left over.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        if (l == 0) begin : g_first
            assign mask[l] = bus.src_valid & {NUM_SRC{~(flush | reset)}};
        end else begin : g_rest
            assign mask[l] = mask[l-1] & ~onehot[l-1];
        end
        rr_pick #(.N(NUM_SRC), .PTR_W(PTR_W)) u_pick (
            .mask   (mask[l]),
            .ptr    (rr_ptr),
            .onehot (onehot[l]),
            .index  (index[l])
        );
        assign lane_hit[l] = |onehot[l];
    end

    always_comb begin
        lane_bits = '0;
        grant     = '0;
        n_bcast   = '0;
        next_ptr  = rr_ptr;
        for (int l = 0; l < NUM_LANES; l++) begin
            grant   = grant | onehot[l];
            n_bcast = n_bcast + {1'b0, lane_hit[l]};
            for (int i = 0; i < NUM_SRC; i++) begin
                if (onehot[l][i]) lane_bits[l] = lane_bits[l] | bus.src_pkt[i];
            end
            // The last lane's winner is furthest along in round-robin order.
            if (lane_hit[l]) begin
                next_ptr = (index[l] == PTR_W'(NUM_SRC - 1)) ? '0 : index[l] + PTR_W'(1);
            end
        end
    end

    assign cnt_sum = {1'b0, cnt} + {15'd0, n_bcast};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (flush)       rr_ptr <= '0;
            else if (|grant) rr_ptr <= next_ptr;
            cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

`ifdef CDB_OUT_REG_EN
    cdb_pkt_t [NUM_LANES-1:0] out_q;
    logic [NUM_LANES-1:0]     valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= '0;
        end else begin
            out_q   <= lane_bits;
            valid_q <= lane_hit;
        end
    end

    assign bus.cdb_out   = out_q;
    assign bus.cdb_valid = valid_q;
`else
    assign bus.cdb_out   = lane_bits;
    assign bus.cdb_valid = lane_hit;
`endif

    assign bus.src_yumi  = grant;
    assign bus.bcast_cnt = cnt;
    assign bus.rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: one-lane and two-lane instances side by side, directed
// sequences plus random traffic against a round-robin reference model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NS = 5;

    typedef struct packed {
        logic [1:0] v;
        cdb_pkt_t   p1;
        cdb_pkt_t   p0;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(NS), .NUM_LANES(1)) bus1 ();
    cdb_arbiter_if #(.NUM_SRC(NS), .NUM_LANES(2)) bus2 ();

    cdb_arbiter #(.NUM_SRC(NS), .NUM_LANES(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus1)
    );
    cdb_arbiter #(.NUM_SRC(NS), .NUM_LANES(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus2)
    );

    // ---------------- source model ----------------
    logic [NS-1:0] pend [2];
    cdb_pkt_t      spkt [2][NS];

    assign bus1.src_valid = pend[0];
    assign bus2.src_valid = pend[1];

    always_comb begin
        bus1.src_pkt = '0;
        bus2.src_pkt = '0;
        for (int i = 0; i < NS; i++) begin
            bus1.src_pkt[i] = spkt[0][i];
            bus2.src_pkt[i] = spkt[1][i];
        end
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    int            m_ptr [2];
    int            m_cnt [2];
    exp_t          exp_q [$];
    logic [NS-1:0] obs_yumi [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [NS-1:0] dut_yumi(input int d);
        return (d == 0) ? bus1.src_yumi : bus2.src_yumi;
    endfunction
    function automatic logic [1:0] dut_valid(input int d);
        return (d == 0) ? {1'b0, bus1.cdb_valid} : bus2.cdb_valid;
    endfunction
    function automatic cdb_pkt_t dut_pkt(input int d, input int l);
        return (d == 0) ? bus1.cdb_out[0] : bus2.cdb_out[l];
    endfunction
    function automatic logic [2:0] dut_ptr(input int d);
        return (d == 0) ? bus1.rr_ptr : bus2.rr_ptr;
    endfunction
    function automatic logic [15:0] dut_cnt(input int d);
        return (d == 0) ? bus1.bcast_cnt : bus2.bcast_cnt;
    endfunction

    // Reference: walk sources from ptr in circular order, take the first `lanes` valid ones.
    function automatic void model_grant(input int lanes, input int ptr, input logic [NS-1:0] v,
                                        output logic [NS-1:0] y, output int a, output int b,
                                        output int n);
        y = '0; a = 0; b = 0; n = 0;
        for (int k = 0; k < NS; k++) begin
            int idx = (ptr + k) % NS;
            if (v[idx] && n < lanes) begin
                y[idx] = 1'b1;
                if (n == 0) a = idx;
                else        b = idx;
                n++;
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_cnt[d] = 0;
        end
        exp_q.delete();
`ifdef CDB_OUT_REG_EN
        exp_q.push_back('0);
        exp_q.push_back('0);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int d, input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) begin
            if (m[i] && !pend[d][i]) begin
                spkt[d][i].rob_tag   = ROB_W'($urandom);
                spkt[d][i].value     = $urandom;
                spkt[d][i].is_branch = 1'($urandom);
                spkt[d][i].taken     = 1'($urandom);
                pend[d][i]           = 1'b1;
            end
        end
    endtask

    // Check one cycle at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic [NS-1:0] ey [2];
        int            w0 [2];
        int            w1 [2];
        int            nw [2];
        int            last;
        exp_t          e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset || flush) begin
                ey[d] = '0; w0[d] = 0; w1[d] = 0; nw[d] = 0;
            end else begin
                model_grant(d + 1, m_ptr[d], pend[d], ey[d], w0[d], w1[d], nw[d]);
            end
            e = '0;
            if (nw[d] > 0) begin e.v[0] = 1'b1; e.p0 = spkt[d][w0[d]]; end
            if (nw[d] > 1) begin e.v[1] = 1'b1; e.p1 = spkt[d][w1[d]]; end
            exp_q.push_back(e);
        end
        for (int d = 0; d < 2; d++) begin
            obs_yumi[d] = dut_yumi(d);
            check($sformatf("yumi_d%0d", d), 64'(obs_yumi[d]), 64'(ey[d]));
            check($sformatf("rr_ptr_d%0d", d), 64'(dut_ptr(d)), 64'(m_ptr[d]));
            check($sformatf("bcast_cnt_d%0d", d), 64'(dut_cnt(d)), 64'(m_cnt[d]));
            e = exp_q.pop_front();
            check($sformatf("cdb_valid_d%0d", d), 64'(dut_valid(d)), 64'(e.v));
            check($sformatf("lane0_d%0d", d), 64'(dut_pkt(d, 0)), 64'(e.p0));
            if (d == 1) check("lane1_d1", 64'(dut_pkt(1, 1)), 64'(e.p1));
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (flush) begin
                    m_ptr[d] = 0;
                end else if (nw[d] > 0) begin
                    last     = (nw[d] > 1) ? w1[d] : w0[d];
                    m_ptr[d] = (last + 1) % NS;
                    m_cnt[d] = (m_cnt[d] + nw[d] > 65535) ? 65535 : m_cnt[d] + nw[d];
                end
                pend[d] = pend[d] & ~ey[d];
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        pend[0] = '0;
        pend[1] = '0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset_cdb_valid", 64'(dut_valid(d)), 64'd0);
            check("reset_cnt", 64'(dut_cnt(d)), 64'd0);
            check("reset_ptr", 64'(dut_ptr(d)), 64'd0);
        end

        // Sources requesting while reset is high must see no yumi.
        set_req(0, 5'b11111);
        set_req(1, 5'b11111);
        repeat (2) tick();
        reset   = 1'b0;
        pend[0] = '0;
        pend[1] = '0;
        tick();

        // One lane: two sources from ptr 0.
        set_req(0, 5'b00101);
        tick();
        check("seq1_yumi_a", 64'(obs_yumi[0]), 64'b00001);
        check("seq1_ptr_a", 64'(dut_ptr(0)), 64'd1);
        tick();
        check("seq1_yumi_b", 64'(obs_yumi[0]), 64'b00100);
        check("seq1_ptr_b", 64'(dut_ptr(0)), 64'd3);

        // Pointer wrap from the last source.
        set_req(0, 5'b01000);
        tick();
        check("wrap_ptr_at4", 64'(dut_ptr(0)), 64'd4);
        set_req(0, 5'b10001);
        tick();
        check("wrap_yumi_a", 64'(obs_yumi[0]), 64'b10000);
        check("wrap_ptr_a", 64'(dut_ptr(0)), 64'd0);
        tick();
        check("wrap_yumi_b", 64'(obs_yumi[0]), 64'b00001);
        check("wrap_ptr_b", 64'(dut_ptr(0)), 64'd1);

        // Two lanes, every source continuously valid.
        set_req(1, 5'b11111);
        tick();
        check("dual_yumi_a", 64'(obs_yumi[1]), 64'b00011);
        set_req(1, 5'b11111);
        tick();
        check("dual_yumi_b", 64'(obs_yumi[1]), 64'b01100);
        set_req(1, 5'b11111);
        tick();
        check("dual_yumi_c", 64'(obs_yumi[1]), 64'b10001);
        check("dual_ptr_c", 64'(dut_ptr(1)), 64'd1);

        // Flush suppresses the grant and rewinds the pointer.
        set_req(0, 5'b00010);
        flush = 1'b1;
        tick();
        check("flush_yumi", 64'(obs_yumi[0]), 64'd0);
        check("flush_ptr", 64'(dut_ptr(0)), 64'd0);
        flush = 1'b0;
        tick();
        check("post_flush_yumi", 64'(obs_yumi[0]), 64'b00010);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            set_req(0, NS'($urandom));
            set_req(1, NS'($urandom & $urandom));
            flush = ($urandom_range(0, 19) == 0);
            tick();
            flush = 1'b0;
        end

        // Reset mid-stream takes effect without a clock edge.
        set_req(0, 5'b11111);
        set_req(1, 5'b11111);
        tick();
        set_req(0, 5'b11111);
        set_req(1, 5'b11111);
        tick();
        #2 reset = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("async_rst_valid", 64'(dut_valid(d)), 64'd0);
            check("async_rst_cnt", 64'(dut_cnt(d)), 64'd0);
            check("async_rst_ptr", 64'(dut_ptr(d)), 64'd0);
            check("async_rst_yumi", 64'(dut_yumi(d)), 64'd0);
        end
        tick();
        reset   = 1'b0;
        pend[0] = '0;
        pend[1] = '0;

        // Saturation: 1 + 32767*2 = 65535 broadcasts on the two-lane instance.
        set_req(1, 5'b00001);
        tick();
        for (int n = 0; n < 32767; n++) begin
            set_req(0, 5'b11111);
            set_req(1, 5'b11111);
            tick();
        end
        check("sat_full", 64'(dut_cnt(1)), 64'hFFFF);
        set_req(1, 5'b11111);
        tick();
        check("sat_hold", 64'(dut_cnt(1)), 64'hFFFF);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5, number of functional-unit result sources (2..8).
REQ-002 SHALL have parameter NUM_LANES, default 1, number of CDB broadcast lanes (1..2).
REQ-003 SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-004 SHALL have parameter DATA_W, default 32, result value width.
REQ-005 SHALL have port clk  input  1  the only clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  mispredict flush that drops all in-flight broadcasts.
REQ-008 SHALL have port src_valid  input  NUM_SRC  per-source result-ready flags.
REQ-009 SHALL have port src_pkt  input  NUM_SRC x cdb_pkt_t  per-source result packet {rob_tag[ROB_W], value[DATA_W], is_branch, taken}.
REQ-010 SHALL have port src_yumi  output  NUM_SRC  per-source consume strobe.
REQ-011 SHALL have port cdb_out  output  NUM_LANES x cdb_pkt_t  broadcast lanes.
REQ-012 SHALL have port cdb_valid  output  NUM_LANES  per-lane broadcast valid.
REQ-013 SHALL have port bcast_cnt  output  16  saturating count of broadcasts.

Function
REQ-014 SHALL grant up to NUM_LANES distinct valid sources per cycle, searching in round-robin order starting at rr_ptr.
REQ-015 SHALL assign the first winner to lane 0 and the second to lane 1.
REQ-016 SHALL drive src_yumi[i] combinationally high iff source i is granted this cycle.
REQ-017 SHALL keep src_yumi and src_valid in a valid/yumi handshake: a source holds valid and its pkt stable until yumi, and the arbiter SHALL never assert yumi without valid.
REQ-018 SHALL set rr_ptr to (highest-order winner index + 1) mod NUM_SRC on any grant; rr_ptr SHALL wrap from NUM_SRC-1 to 0 and SHALL hold when nothing is granted.
REQ-019 SHALL, with fewer valid sources than lanes, leave the unused lanes at cdb_valid=0.
REQ-020 SHALL, when flush=1, assert no yumi in that cycle, clear all cdb_valid on the next edge, and load rr_ptr with 0.
REQ-021 SHALL increment bcast_cnt by the number of valid lanes broadcast per cycle, saturating at 16'hFFFF; bcast_cnt SHALL be unaffected by flush.
REQ-022 SHALL bound the wait of any continuously valid source to ceil((NUM_SRC-1)/NUM_LANES) cycles before it is granted.

Reset
REQ-023 SHALL, on reset, asynchronously clear cdb_valid to all-zeros, cdb_out to all-zeros, rr_ptr to 0 and bcast_cnt to 0.
REQ-024 SHALL hold src_yumi at 0 while reset is high.
REQ-025 SHALL abort any in-progress broadcast when reset is asserted mid-operation, with no partial lane left valid.

Configuration
REQ-026 SHALL support macro CDB_OUT_REG_EN, which when defined makes cdb_out/cdb_valid registered, giving 1-cycle latency from yumi to broadcast.
REQ-027 SHALL, when CDB_OUT_REG_EN is undefined, drive cdb_out/cdb_valid combinationally from the current grant (0-cycle latency), with flush forcing cdb_valid to 0 in the same cycle.

Structure
REQ-028 SHALL define cdb_pkt_t and the default ROB_W/DATA_W localparams in shared package cdb_pkg.
REQ-029 SHALL use one sub-module, rr_pick, a one-hot round-robin picker (inputs mask and ptr, outputs onehot and index), instantiated NUM_LANES times, with each later instance's mask excluding earlier winners.

Verification
REQ-030 SHALL verify (NUM_LANES=1): src_valid=5'b00101 with rr_ptr=0 gives yumi=00001; next cycle yumi=00100, rr_ptr=3, and cdb_out carries source 0's then source 2's tag.
REQ-031 SHALL verify wrap: rr_ptr=4, src_valid=5'b10001 gives a grant to source 4 first and then to source 0, with rr_ptr passing 0 then 1.
REQ-032 SHALL verify (NUM_LANES=2): src_valid=5'b11111, rr_ptr=0 gives yumi=00011, then 01100, then 10001, with both lanes valid every cycle.
REQ-033 SHALL verify flush: flush=1 with src_valid=5'b00010 gives yumi=0, cdb_valid=0 the next cycle and rr_ptr=0; source 1 is granted the cycle after flush drops.
REQ-034 SHALL verify saturation: bcast_cnt preloaded via 65535 grants stays at 16'hFFFF after a further grant.
REQ-035 SHALL verify reset asserted mid-stream with src_valid=5'b11111 clears cdb_valid, bcast_cnt and rr_ptr immediately, without waiting for clk.
